// File: rtl/mul_pipe_ctrl.sv
// Sequencer for the two-stage integer multiplier: owns the mul_0/mul_1 pipeline
// registers, handles writeback back-pressure and flush, and reports in-flight rd tags.
module mul_pipe_ctrl #(
   parameter int RD_W    = 5,
   parameter int PP_W    = 36,
   parameter bit DROP_R0 = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [RD_W-1:0] in_rd,
   input  logic            in_sel,
   input  logic            in_usign,
   input  logic [31:0]     in_sr0,
   input  logic [31:0]     in_sr1,
   output logic            m0_en,
   output logic [RD_W-1:0] m0_rd,
   output logic            m0_sel,
   output logic            m0_usign,
   output logic [31:0]     m0_sr0,
   output logic [31:0]     m0_sr1,
   input  logic [PP_W-1:0] m0_rs0,
   input  logic [PP_W-1:0] m0_rs1,
   input  logic [PP_W-1:0] m0_rs2,
   input  logic [PP_W-1:0] m0_rs3,
   output logic            m1_en,
   output logic [RD_W-1:0] m1_rd,
   output logic            m1_sel,
   output logic [PP_W-1:0] m1_sr0,
   output logic [PP_W-1:0] m1_sr1,
   output logic [PP_W-1:0] m1_sr2,
   output logic [PP_W-1:0] m1_sr3,
   input  logic [31:0]     m1_result,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [RD_W-1:0] wb_rd,
   output logic [31:0]     wb_data,
   output logic            s0_busy,
   output logic [RD_W-1:0] s0_rd,
   output logic            s1_busy,
   output logic [RD_W-1:0] s1_rd
);

   typedef struct packed {
      logic            v;
      logic [RD_W-1:0] rd;
      logic            sel;
      logic            usign;
      logic [31:0]     sr0;
      logic [31:0]     sr1;
   } s0_t;

   typedef struct packed {
      logic            v;
      logic [RD_W-1:0] rd;
      logic            sel;
      logic [PP_W-1:0] rs0;
      logic [PP_W-1:0] rs1;
      logic [PP_W-1:0] rs2;
      logic [PP_W-1:0] rs3;
   } s1_t;

   s0_t  s0_q;
   s1_t  s1_q;
   logic drop1;
   logic wb_fire;
   logic s1_free;
   logic s0_mv;
   logic accept;

   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      drop1    = DROP_R0 && (s1_q.rd == '0);
      wb_fire  = s1_q.v && (wb_ready || drop1);
      s1_free  = !s1_q.v || wb_fire;
      s0_mv    = s0_q.v && s1_free;
      in_ready = !flush && (!s0_q.v || s0_mv);
      accept   = in_valid && in_ready;
   end

   // NOTE: data/tag registers are reset too, so tag outputs read as zero straight after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         s0_q <= '0;
         s1_q <= '0;
      end else if (flush) begin
         // Flush only kills the valids; payload registers keep their contents.
         s0_q.v <= 1'b0;
         s1_q.v <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let S1 capture the old S0 while S0 loads new input in the same edge.
         if (s0_mv)
            s1_q <= {1'b1, s0_q.rd, s0_q.sel, m0_rs0, m0_rs1, m0_rs2, m0_rs3};
         else if (wb_fire)
            s1_q.v <= 1'b0;

         if (accept)
            s0_q <= {1'b1, in_rd, in_sel, in_usign, in_sr0, in_sr1};
         else if (s0_mv)
            s0_q.v <= 1'b0;
      end
   end

   assign m0_en    = s0_q.v;
   assign m0_rd    = s0_q.rd;
   assign m0_sel   = s0_q.sel;
   assign m0_usign = s0_q.usign;
   assign m0_sr0   = s0_q.sr0;
   assign m0_sr1   = s0_q.sr1;

   assign m1_en    = s1_q.v;
   assign m1_rd    = s1_q.rd;
   assign m1_sel   = s1_q.sel;
   assign m1_sr0   = s1_q.rs0;
   assign m1_sr1   = s1_q.rs1;
   assign m1_sr2   = s1_q.rs2;
   assign m1_sr3   = s1_q.rs3;

   // Dropped rd==0 ops neither write back nor count as a hazard.
   assign wb_valid = s1_q.v && !drop1;
   assign wb_rd    = s1_q.rd;
   assign wb_data  = m1_result;

   assign s0_busy  = s0_q.v;
   assign s0_rd    = s0_q.rd;
   assign s1_busy  = s1_q.v && !drop1;
   assign s1_rd    = s1_q.rd;

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Self-checking bench for mul_pipe_ctrl: behavioural mul_0/mul_1 stand-ins,
// an in-order queue reference model, table vectors, corner sequences and random traffic.
module tb_mul_pipe_ctrl;
   localparam int RD_W = 5;
   localparam int PP_W = 36;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, flush, in_valid, in_ready, in_sel, in_usign, wb_ready;
   logic [RD_W-1:0] in_rd;
   logic [31:0]     in_sr0, in_sr1;
   logic            m0_en, m0_sel, m0_usign;
   logic [RD_W-1:0] m0_rd;
   logic [31:0]     m0_sr0, m0_sr1;
   logic [PP_W-1:0] m0_rs0, m0_rs1, m0_rs2, m0_rs3;
   logic            m1_en, m1_sel;
   logic [RD_W-1:0] m1_rd;
   logic [PP_W-1:0] m1_sr0, m1_sr1, m1_sr2, m1_sr3;
   logic [31:0]     m1_result;
   logic            wb_valid, s0_busy, s1_busy;
   logic [RD_W-1:0] wb_rd, s0_rd, s1_rd;
   logic [31:0]     wb_data;

   mul_pipe_ctrl #(.RD_W(RD_W), .PP_W(PP_W), .DROP_R0(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_sel(in_sel),
      .in_usign(in_usign), .in_sr0(in_sr0), .in_sr1(in_sr1),
      .m0_en(m0_en), .m0_rd(m0_rd), .m0_sel(m0_sel), .m0_usign(m0_usign),
      .m0_sr0(m0_sr0), .m0_sr1(m0_sr1),
      .m0_rs0(m0_rs0), .m0_rs1(m0_rs1), .m0_rs2(m0_rs2), .m0_rs3(m0_rs3),
      .m1_en(m1_en), .m1_rd(m1_rd), .m1_sel(m1_sel),
      .m1_sr0(m1_sr0), .m1_sr1(m1_sr1), .m1_sr2(m1_sr2), .m1_sr3(m1_sr3),
      .m1_result(m1_result),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .s0_busy(s0_busy), .s0_rd(s0_rd), .s1_busy(s1_busy), .s1_rd(s1_rd)
   );

   function automatic logic [63:0] full_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
      logic signed [63:0] sa, sb;
      if (sgn) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
         return 64'(sa * sb);
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   // Partial products carry distinct upper nibbles so PP_W truncation is visible.
   function automatic logic [PP_W-1:0] pp(input int idx, input logic [31:0] a,
                                          input logic [31:0] b, input logic sgn);
      logic [63:0] p;
      p = full_prod(a, b, sgn);
      case (idx)
         0:       return {p[63:60], p[31:0]};
         1:       return {p[3:0], p[63:32]};
         2:       return {4'h5, a ^ b};
         default: return {4'hA, a + b};
      endcase
   endfunction

   assign m0_rs0    = pp(0, m0_sr0, m0_sr1, m0_usign);
   assign m0_rs1    = pp(1, m0_sr0, m0_sr1, m0_usign);
   assign m0_rs2    = pp(2, m0_sr0, m0_sr1, m0_usign);
   assign m0_rs3    = pp(3, m0_sr0, m0_sr1, m0_usign);
   assign m1_result = m1_sel ? m1_sr1[31:0] : m1_sr0[31:0];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: in-order list of live ops, oldest first, each tagged with whether it
   // has reached the second register yet.
   typedef struct {
      logic [RD_W-1:0] rd;
      logic            sel;
      logic            usign;
      logic [31:0]     sr0;
      logic [31:0]     sr1;
      bit              late;
   } op_t;

   op_t q[$];
   logic            last_wbv, last_inr, last_s0b, last_s1b;
   logic [31:0]     last_wbd;
   logic [RD_W-1:0] last_wbrd;

   task automatic cycle(input logic v, input logic [RD_W-1:0] rd, input logic sel,
                        input logic usign, input logic [31:0] a, input logic [31:0] b,
                        input logic wbr, input logic fl, input logic r);
      bit   has_late, has_early, drop, exp_wbv, retire, s1_free, mv, exp_inr;
      op_t  h, n;
      @(negedge clk);
      in_valid = v; in_rd = rd; in_sel = sel; in_usign = usign;
      in_sr0 = a; in_sr1 = b; wb_ready = wbr; flush = fl; rst = r;
      #1;
      last_wbv = wb_valid; last_wbd = wb_data; last_wbrd = wb_rd;
      last_inr = in_ready; last_s0b = s0_busy; last_s1b = s1_busy;

      has_late  = (q.size() > 0) && q[0].late;
      has_early = (q.size() > 0) && !q[q.size()-1].late;
      drop      = has_late && (q[0].rd == '0);
      exp_wbv   = has_late && !drop;
      check("wb_valid", 64'(wb_valid), 64'(exp_wbv));
      check("s1_busy", 64'(s1_busy), 64'(exp_wbv));
      check("s0_busy", 64'(s0_busy), 64'(has_early));
      if (exp_wbv) begin
         h = q[0];
         check("wb_rd", 64'(wb_rd), 64'(h.rd));
         check("wb_data", 64'(wb_data),
               64'(h.sel ? full_prod(h.sr0, h.sr1, h.usign) >> 32
                         : full_prod(h.sr0, h.sr1, h.usign) & 64'hFFFF_FFFF));
         check("m1_sr2", 64'(m1_sr2), 64'(pp(2, h.sr0, h.sr1, h.usign)));
         check("m1_sr3", 64'(m1_sr3), 64'(pp(3, h.sr0, h.sr1, h.usign)));
      end
      if (has_early) begin
         h = q[q.size()-1];
         check("s0_rd", 64'(s0_rd), 64'(h.rd));
         check("m0_sr0", 64'(m0_sr0), 64'(h.sr0));
      end
      retire  = has_late && (wbr || drop);
      s1_free = !has_late || retire;
      mv      = has_early && s1_free;
      exp_inr = !fl && (!has_early || mv);
      check("in_ready", 64'(in_ready), 64'(exp_inr));

      if (r || fl) q.delete();
      else begin
         if (retire) void'(q.pop_front());
         if (mv) q[0].late = 1'b1;
         if (v && exp_inr) begin
            n = '{rd: rd, sel: sel, usign: usign, sr0: a, sr1: b, late: 1'b0};
            q.push_back(n);
         end
      end
   endtask

   task automatic idle(input logic wbr);
      cycle(1'b0, '0, 1'b0, 1'b0, 32'd0, 32'd0, wbr, 1'b0, 1'b0);
   endtask

   typedef struct {
      logic [31:0]     sr0;
      logic [31:0]     sr1;
      logic            sel;
      logic            usign;
      logic [RD_W-1:0] rd;
      logic [31:0]     exp_data;
   } vec_t;

   vec_t vecs[8];
   logic [31:0] held;

   initial begin
      vecs[0] = '{32'd7,        32'd6,        1'b0, 1'b0, 5'd3,  32'd42};
      vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd4,  32'hFFFFFFFE};
      vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd5,  32'h00000000};
      vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd6,  32'h00000001};
      vecs[4] = '{32'h80000000, 32'd2,        1'b1, 1'b0, 5'd7,  32'h00000001};
      vecs[5] = '{32'h80000000, 32'd2,        1'b1, 1'b1, 5'd8,  32'hFFFFFFFF};
      vecs[6] = '{32'hFFFFFFFF, 32'd2,        1'b1, 1'b1, 5'd9,  32'hFFFFFFFF};
      vecs[7] = '{32'h00010000, 32'h00010000, 1'b0, 1'b0, 5'd31, 32'h00000000};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rd = '0; in_sel = 1'b0;
      in_usign = 1'b0; in_sr0 = '0; in_sr1 = '0; wb_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_wb_valid", 64'(wb_valid), 64'd0);
      check("rst_busy", 64'({s0_busy, s1_busy, m0_en, m1_en}), 64'd0);
      check("rst_tags", 64'({s0_rd, s1_rd, wb_rd}), 64'd0);
      check("rst_m0_sr", 64'({m0_sr0, m0_sr1}), 64'd0);
      check("rst_m1_sr0", 64'(m1_sr0), 64'd0);

      // Single ops: two-register latency and hand-computed results
      foreach (vecs[i]) begin
         cycle(1'b1, vecs[i].rd, vecs[i].sel, vecs[i].usign, vecs[i].sr0, vecs[i].sr1,
               1'b1, 1'b0, 1'b0);
         idle(1'b1);
         check("lat_early", 64'(last_wbv), 64'd0);
         idle(1'b1);
         check("lat_valid", 64'(last_wbv), 64'd1);
         check("vec_data", 64'(last_wbd), 64'(vecs[i].exp_data));
         check("vec_rd", 64'(last_wbrd), 64'(vecs[i].rd));
      end

      // Back-to-back: in_ready stays high, results stream without bubbles
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 5'(10 + i), 1'b0, 1'b0, 32'(i + 2), 32'd3, 1'b1, 1'b0, 1'b0);
         check("b2b_in_ready", 64'(last_inr), 64'd1);
      end
      for (int i = 0; i < 2; i++) begin
         idle(1'b1);
         check("b2b_stream", 64'(last_wbv), 64'd1);
      end
      idle(1'b1); idle(1'b1);

      // Back-pressure: third op refused, S1 held constant, release drains in order
      cycle(1'b1, 5'd1, 1'b0, 1'b0, 32'd11, 32'd13, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 5'd2, 1'b0, 1'b0, 32'd17, 32'd19, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 5'd3, 1'b0, 1'b0, 32'd23, 32'd29, 1'b0, 1'b0, 1'b0);
      check("bp_in_ready", 64'(last_inr), 64'd0);
      held = last_wbd;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 5'd3, 1'b0, 1'b0, 32'd23, 32'd29, 1'b0, 1'b0, 1'b0);
         check("bp_hold", 64'(last_wbd), 64'(held));
      end
      check("bp_data", 64'(held), 64'd143);
      cycle(1'b1, 5'd3, 1'b0, 1'b0, 32'd23, 32'd29, 1'b1, 1'b0, 1'b0);
      check("bp_release", 64'(last_inr), 64'd1);
      repeat (4) idle(1'b1);

      // Flush with both stages full
      cycle(1'b1, 5'd4, 1'b0, 1'b0, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 5'd5, 1'b0, 1'b0, 32'd6, 32'd6, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 5'd6, 1'b0, 1'b0, 32'd7, 32'd7, 1'b0, 1'b1, 1'b0);
      check("fl_in_ready", 64'(last_inr), 64'd0);
      idle(1'b1);
      check("fl_cleared", 64'({last_wbv, last_s0b, last_s1b}), 64'd0);
      repeat (2) idle(1'b1);

      // rd==0 retires silently while the rd=5 op behind it stalls
      cycle(1'b1, 5'd0, 1'b0, 1'b0, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 5'd5, 1'b0, 1'b0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 5'd5, 1'b0, 1'b0, 32'd8, 32'd8, 1'b0, 1'b0, 1'b0);
      check("drop_silent", 64'({last_wbv, last_s1b}), 64'd0);
      check("drop_accept", 64'(last_inr), 64'd1);
      idle(1'b0);
      check("drop_next", 64'(last_wbv), 64'd1);
      check("drop_next_rd", 64'(last_wbrd), 64'd5);
      idle(1'b0);
      check("drop_stall", 64'({last_wbv, last_s0b}), 64'h3);
      repeat (3) idle(1'b1);

      // Reset with two ops in flight
      cycle(1'b1, 5'd7, 1'b1, 1'b0, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 5'd8, 1'b1, 1'b0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 5'd9, 1'b0, 1'b0, 32'd5, 32'd6, 1'b0, 1'b1, 1'b1);
      idle(1'b1);
      check("rst_mid_busy", 64'({last_wbv, last_s0b, last_s1b}), 64'd0);
      check("rst_mid_ready", 64'(last_inr), 64'd1);
      check("rst_mid_regs", 64'({m0_sr0, m0_rd, wb_rd}), 64'd0);
      repeat (3) idle(1'b1);

      // Random traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 9) < 7, RD_W'($urandom_range(0, 3)), 1'($urandom),
               1'($urandom), $urandom, $urandom, $urandom_range(0, 3) != 0,
               $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
